// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared opcode constants, immediate formats and decoded-control
//            bundle for the RV32 decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // Major opcodes recognised by the decoder (everything else is illegal)
  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP = 7'b0010011;
  localparam logic [6:0] I_TYPE_LD = 7'b0000011;
  localparam logic [6:0] U_TYPE    = 7'b0110111;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] S_TYPE    = 7'b0100011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  // Control part of the output bundle (data-width fields live beside it)
  typedef struct packed {
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] alu_op;
    logic       alu_sub_sra;
    logic [4:0] rd;
    logic       rd_write;
    logic       branch;
    logic       illegal;
  } decode_t;

  // 32-bit sign-extended immediate for the given format
  function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] v;
    v = 32'd0;
    case (fmt)
      IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   v = {ins[31:12], 12'd0};
      IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard
// Purpose  : Per-register pending-write counters; produces the read-after-
//            write hazard and counter-saturation stall terms. Optional
//            same-cycle writeback lift controlled by DECODE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
  parameter int NREGS  = 32,
  parameter int PEND_W = 2,
  parameter int IDXW   = 5
) (
  input  logic       req,
  input  logic       reset,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       rd_write,
  input  logic       fire,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush_dec,
  input  logic [4:0] flush_rd,
  output logic       hazard,
  output logic       sat
);

  logic [PEND_W-1:0] r_pend [NREGS];
  logic [PEND_W-1:0] w_next [NREGS];
  logic [PEND_W-1:0] w_p1, w_p2, w_prd;
  logic              w_lift1, w_lift2;

  assign w_p1  = r_pend[rs1[IDXW-1:0]];
  assign w_p2  = r_pend[rs2[IDXW-1:0]];
  assign w_prd = r_pend[rd[IDXW-1:0]];

`ifdef DECODE_BYPASS_EN
  // Last outstanding write landing this cycle is forwarded, so no stall
  assign w_lift1 = (w_p1 == PEND_W'(1)) && wb_valid && (wb_rd == rs1);
  assign w_lift2 = (w_p2 == PEND_W'(1)) && wb_valid && (wb_rd == rs2);
`else
  assign w_lift1 = 1'b0;
  assign w_lift2 = 1'b0;
`endif

  assign hazard = (rs1_used && (w_p1 != '0) && !w_lift1) ||
                  (rs2_used && (w_p2 != '0) && !w_lift2);
  assign sat    = rd_write && (w_prd == '1);

  // Next counter value: +issue, -writeback, -flushed writer, floor at zero
  always_comb begin
    logic [PEND_W:0] w_sum;
    logic [PEND_W:0] w_dec;
    w_sum = '0;
    w_dec = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_sum = {1'b0, r_pend[i]} + (PEND_W+1)'(fire && rd_write && (rd == 5'(i)));
      w_dec = (PEND_W+1)'(wb_valid && (wb_rd == 5'(i))) +
              (PEND_W+1)'(flush_dec && (flush_rd == 5'(i)));
      w_next[i] = (w_sum > w_dec) ? PEND_W'(w_sum - w_dec) : '0;
    end
  end

  // Counter state update
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= w_next[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Purpose  : RV32 decode stage: register file, scoreboard-based RAW stall,
//            immediate generation and one valid/ready output register.
//            Macro DECODE_BYPASS_EN enables same-cycle writeback forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic            req,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush_in,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [6:0]      alu_op_out,
  output logic            alu_sub_sra_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic            branch_out,
  output logic            illegal_out
);

  localparam int IDXW = (NREGS > 16) ? 5 : 4;

  logic [XLEN-1:0] r_rf [NREGS];
  logic            r_out_valid;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
  decode_t         r_ctl;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  imm_fmt_e        w_fmt;
  logic            w_known, w_use1, w_use2, w_has_rd, w_illegal;
  logic            w_rs1_used, w_rs2_used, w_rd_write;
  logic [XLEN-1:0] w_imm, w_src1, w_src2;
  decode_t         w_ctl;
  logic            w_hazard, w_sat, w_fire, w_flush_dec;

  assign w_opcode = instr_in[6:0];
  assign w_rd     = instr_in[11:7];
  assign w_rs1    = instr_in[19:15];
  assign w_rs2    = instr_in[24:20];

  // Format classification and source/destination usage per opcode
  always_comb begin
    w_fmt    = IMM_NONE;
    w_known  = 1'b1;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_has_rd = 1'b0;
    case (w_opcode)
      R_TYPE:               begin w_use1 = 1'b1; w_use2 = 1'b1; w_has_rd = 1'b1; end
      I_TYPE_OP, I_TYPE_LD: begin w_fmt = IMM_I; w_use1 = 1'b1; w_has_rd = 1'b1; end
      S_TYPE:               begin w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; end
      B_TYPE:               begin w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; end
      U_TYPE:               begin w_fmt = IMM_U; w_has_rd = 1'b1; end
      J_TYPE:               begin w_fmt = IMM_J; w_has_rd = 1'b1; end
      default:              w_known = 1'b0;
    endcase
  end

  // Illegal instructions neither read sources nor claim a destination
  assign w_illegal  = !w_known ||
                      (w_use1   && !({27'd0, w_rs1} < NREGS)) ||
                      (w_use2   && !({27'd0, w_rs2} < NREGS)) ||
                      (w_has_rd && !({27'd0, w_rd}  < NREGS));
  assign w_rs1_used = w_use1 && !w_illegal;
  assign w_rs2_used = w_use2 && !w_illegal;
  assign w_rd_write = w_has_rd && !w_illegal && (w_rd != 5'd0);

  assign w_imm = XLEN'($signed(imm32(instr_in, w_fmt)));

`ifdef DECODE_BYPASS_EN
  assign w_src1 = (wb_valid && (wb_rd == w_rs1) && (w_rs1 != 5'd0)) ? wb_value : r_rf[w_rs1[IDXW-1:0]];
  assign w_src2 = (wb_valid && (wb_rd == w_rs2) && (w_rs2 != 5'd0)) ? wb_value : r_rf[w_rs2[IDXW-1:0]];
`else
  assign w_src1 = r_rf[w_rs1[IDXW-1:0]];
  assign w_src2 = r_rf[w_rs2[IDXW-1:0]];
`endif

  // Assemble the control bundle captured on issue
  always_comb begin
    w_ctl             = '0;
    w_ctl.funct3      = instr_in[14:12];
    w_ctl.funct7      = instr_in[31:25];
    w_ctl.alu_op      = w_opcode;
    w_ctl.alu_sub_sra = ((w_opcode == R_TYPE) ||
                         ((w_opcode == I_TYPE_OP) && (instr_in[14:12] == 3'b101))) ? instr_in[30] : 1'b0;
    w_ctl.rd          = w_rd;
    w_ctl.rd_write    = w_rd_write;
    w_ctl.branch      = (w_opcode == B_TYPE) || (w_opcode == J_TYPE);
    w_ctl.illegal     = w_illegal;
  end

  // A flushed output instruction gives back its scoreboard reservation
  assign w_flush_dec = flush_in && r_out_valid && r_ctl.rd_write;

  decode_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W),
    .IDXW   (IDXW)
  ) u_scoreboard (
    .req       (req),
    .reset     (reset),
    .rs1       (w_rs1),
    .rs2       (w_rs2),
    .rs1_used  (w_rs1_used),
    .rs2_used  (w_rs2_used),
    .rd        (w_rd),
    .rd_write  (w_rd_write),
    .fire      (w_fire),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush_dec (w_flush_dec),
    .flush_rd  (r_ctl.rd),
    .hazard    (w_hazard),
    .sat       (w_sat)
  );

  assign in_ready = reset && !flush_in && !w_hazard && !w_sat && (!r_out_valid || out_ready);
  assign w_fire   = in_valid && in_ready;

  // Register file write port; x0 and out-of-range indices are never written
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_valid && (wb_rd != 5'd0) && ({27'd0, wb_rd} < NREGS)) begin
      r_rf[wb_rd[IDXW-1:0]] <= wb_value;
    end
  end

  // Output pipeline register: load on issue, hold under backpressure
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_ctl       <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_pc        <= pc_in;
      r_rs1       <= w_rs1_used ? w_src1 : '0;
      r_rs2       <= w_rs2_used ? w_src2 : '0;
      r_imm       <= w_imm;
      r_ctl       <= w_ctl;
    end else if (flush_in || out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign pc_out          = r_pc;
  assign rs1_value_out   = r_rs1;
  assign rs2_value_out   = r_rs2;
  assign imm_value_out   = r_imm;
  assign funct3_out      = r_ctl.funct3;
  assign funct7_out      = r_ctl.funct7;
  assign alu_op_out      = r_ctl.alu_op;
  assign alu_sub_sra_out = r_ctl.alu_sub_sra;
  assign rd_out          = r_ctl.rd;
  assign rd_write_out    = r_ctl.rd_write;
  assign branch_out      = r_ctl.branch;
  assign illegal_out     = r_ctl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_pipe
// Purpose  : Directed self-checking bench for decode_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0110111, OP_S = 7'b0100011;

  logic            req, reset, in_valid, in_ready, flush_in, wb_valid, out_valid, out_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in, wb_value, pc_out, rs1_value_out, rs2_value_out, imm_value_out;
  logic [4:0]      wb_rd, rd_out;
  logic [2:0]      funct3_out;
  logic [6:0]      funct7_out, alu_op_out;
  logic            alu_sub_sra_out, rd_write_out, branch_out, illegal_out;

  int n_vec = 0;
  int n_err = 0;

  decode_pipe #(.XLEN(XLEN), .NREGS(32), .PEND_W(2)) dut (
    .req(req), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush_in(flush_in),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
    .imm_value_out(imm_value_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
    .alu_op_out(alu_op_out), .alu_sub_sra_out(alu_sub_sra_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .branch_out(branch_out), .illegal_out(illegal_out)
  );

  initial req = 1'b0;
  always #5 req = ~req;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge req);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] r, input logic [XLEN-1:0] v);
    wb_valid = 1'b1; wb_rd = r; wb_value = v;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    in_valid = 1'b1; instr_in = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OP_I);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (pc_out !== 32'd0 || imm_value_out !== 32'd0 || rs1_value_out !== 32'd0)
      begin n_err++; $display("FAIL rst_data: got pc %h imm %h rs1 %h want all 0", pc_out, imm_value_out, rs1_value_out); end
    n_vec++; if (illegal_out !== 1'b0 || rd_write_out !== 1'b0)
      begin n_err++; $display("FAIL rst_flags: got ill %b rdw %b want 0 0", illegal_out, rd_write_out); end
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    do_wb(5'd1, 32'd5);
    do_wb(5'd2, 32'd7);
  endtask

  task automatic test_add();
    pc_in = 32'h100; instr_in = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_R); in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_vec++; if (rs1_value_out !== 32'd5) begin n_err++; $display("FAIL add_rs1: got %0d want 5", rs1_value_out); end
    n_vec++; if (rs2_value_out !== 32'd7) begin n_err++; $display("FAIL add_rs2: got %0d want 7", rs2_value_out); end
    n_vec++; if (rd_out !== 5'd3 || rd_write_out !== 1'b1)
      begin n_err++; $display("FAIL add_rd: got rd %0d rdw %b want 3 1", rd_out, rd_write_out); end
    n_vec++; if (pc_out !== 32'h100 || alu_op_out !== OP_R || alu_sub_sra_out !== 1'b0)
      begin n_err++; $display("FAIL add_ctl: got pc %h op %b sub %b want 100 0110011 0", pc_out, alu_op_out, alu_sub_sra_out); end
  endtask

  task automatic test_raw();
    pc_in = 32'h104; instr_in = enc_i(12'd1, 5'd3, 3'd0, 5'd4, OP_I); in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b want 0", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL raw_no_issue: got %b want 0", out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_value = 32'd12;
    #1;
`ifdef DECODE_BYPASS_EN
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_bypass_ready: got %b want 1", in_ready); end
    tick();
    wb_valid = 1'b0;
`else
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_wb_stall: got %b want 0", in_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", in_ready); end
    tick();
`endif
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || rs1_value_out !== 32'd12)
      begin n_err++; $display("FAIL raw_value: got v %b rs1 %0d want 1 12", out_valid, rs1_value_out); end
    n_vec++; if (rd_out !== 5'd4 || imm_value_out !== 32'd1)
      begin n_err++; $display("FAIL raw_fields: got rd %0d imm %h want 4 1", rd_out, imm_value_out); end
    tick();
    do_wb(5'd4, 32'd13);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; pc_in = 32'h200; instr_in = {20'h12345, 5'd5, OP_U}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (out_valid !== 1'b1 || imm_value_out !== 32'h12345000 || pc_out !== 32'h200 || rd_out !== 5'd5)
        begin n_err++; $display("FAIL bp_hold[%0d]: got v %b imm %h pc %h rd %0d want 1 12345000 200 5", k, out_valid, imm_value_out, pc_out, rd_out); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_still_valid: got %b want 1", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_consume: got %b want 0", out_valid); end
    do_wb(5'd5, 32'h12345000);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; pc_in = 32'h300; instr_in = enc_i(12'd0, 5'd1, 3'b010, 5'd6, OP_LD); in_valid = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || rd_out !== 5'd6 || rd_write_out !== 1'b1 || alu_op_out !== OP_LD || rs1_value_out !== 32'd5)
      begin n_err++; $display("FAIL lw_issue: got v %b rd %0d rdw %b op %b rs1 %0d want 1 6 1 0000011 5", out_valid, rd_out, rd_write_out, alu_op_out, rs1_value_out); end
    flush_in = 1'b1; instr_in = enc_i(12'd3, 5'd0, 3'd0, 5'd10, OP_I);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_blocks: got %b want 0", in_ready); end
    tick();
    flush_in = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill: got %b want 0", out_valid); end
    out_ready = 1'b1; instr_in = enc_r(7'd0, 5'd0, 5'd6, 3'd0, 5'd9, OP_R);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_dec: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || rd_out !== 5'd9 || rs1_value_out !== 32'd0)
      begin n_err++; $display("FAIL flush_next: got v %b rd %0d rs1 %0d want 1 9 0", out_valid, rd_out, rs1_value_out); end
    tick();
    do_wb(5'd9, 32'd0);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; instr_in = enc_i(12'd1, 5'd0, 3'd0, 5'd7, OP_I); in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sat_issue[%0d]: got %b want 1", k, in_ready); end
      tick();
    end
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sat_stall: got %b want 0", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_no_issue: got %b want 0", out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_value = 32'd21;
    tick();
    wb_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sat_release: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || rd_out !== 5'd7)
      begin n_err++; $display("FAIL sat_fourth: got v %b rd %0d want 1 7", out_valid, rd_out); end
    repeat (3) do_wb(5'd7, 32'd21);
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; instr_in = enc_i(12'd0, 5'd0, 3'd0, 5'd11, 7'b1111111); in_valid = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || illegal_out !== 1'b1 || rd_write_out !== 1'b0)
      begin n_err++; $display("FAIL ill_flags: got v %b ill %b rdw %b want 1 1 0", out_valid, illegal_out, rd_write_out); end
    instr_in = enc_r(7'd0, 5'd0, 5'd11, 3'd0, 5'd12, OP_R);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_no_pend: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (illegal_out !== 1'b0 || rd_out !== 5'd12)
      begin n_err++; $display("FAIL ill_next: got ill %b rd %0d want 0 12", illegal_out, rd_out); end
    tick();
    do_wb(5'd12, 32'd0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    instr_in = enc_r(7'b0100000, 5'd1, 5'd2, 3'd0, 5'd13, OP_R);
    tick();
    n_vec++; if (alu_sub_sra_out !== 1'b1 || rs1_value_out !== 32'd7 || rs2_value_out !== 32'd5 || funct7_out !== 7'h20)
      begin n_err++; $display("FAIL b2b_sub: got sub %b rs1 %0d rs2 %0d f7 %h want 1 7 5 20", alu_sub_sra_out, rs1_value_out, rs2_value_out, funct7_out); end
    instr_in = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);
    tick();
    n_vec++; if (out_valid !== 1'b1 || branch_out !== 1'b1 || imm_value_out !== 32'hFFFF_FFF8 || rd_write_out !== 1'b0)
      begin n_err++; $display("FAIL b2b_beq: got v %b br %b imm %h rdw %b want 1 1 fffffff8 0", out_valid, branch_out, imm_value_out, rd_write_out); end
    instr_in = enc_s(12'hFFC, 5'd2, 5'd1, 3'b010);
    tick();
    n_vec++; if (imm_value_out !== 32'hFFFF_FFFC || branch_out !== 1'b0 || rd_write_out !== 1'b0 || funct3_out !== 3'b010 || rs2_value_out !== 32'd7)
      begin n_err++; $display("FAIL b2b_sw: got imm %h br %b rdw %b f3 %b rs2 %0d want fffffffc 0 0 010 7", imm_value_out, branch_out, rd_write_out, funct3_out, rs2_value_out); end
    instr_in = enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd14, OP_I);
    tick();
    in_valid = 1'b0;
    n_vec++; if (alu_sub_sra_out !== 1'b1 || imm_value_out !== 32'h403 || rd_out !== 5'd14)
      begin n_err++; $display("FAIL b2b_srai: got sub %b imm %h rd %0d want 1 403 14", alu_sub_sra_out, imm_value_out, rd_out); end
    tick();
    do_wb(5'd13, 32'd2);
    do_wb(5'd14, 32'd0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; instr_in = enc_i(12'd1, 5'd0, 3'd0, 5'd15, OP_I); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstm_pre: got %b want 1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || rd_out !== 5'd0 || imm_value_out !== 32'd0)
      begin n_err++; $display("FAIL rstm_async: got v %b rd %0d imm %h want 0 0 0", out_valid, rd_out, imm_value_out); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstm_ready: got %b want 0", in_ready); end
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstm_ready_hold: got %b want 0", in_ready); end
    reset = 1'b1; out_ready = 1'b1;
    instr_in = enc_r(7'd0, 5'd15, 5'd1, 3'd0, 5'd16, OP_R); in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstm_cnt_clear: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || rs1_value_out !== 32'd0)
      begin n_err++; $display("FAIL rstm_rf_clear: got v %b rs1 %0d want 1 0", out_valid, rs1_value_out); end
    tick();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; instr_in = 32'd0; pc_in = '0; flush_in = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_value = '0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_raw();
    test_backpressure();
    test_flush();
    test_saturation();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised RV32 decode stage with an integrated register file, a register scoreboard and a valid/ready handshake on both sides.
- Sits between fetch and execute.
- Decodes one instruction per cycle into a single output pipeline register.
- Stalls fetch on read-after-write hazards against in-flight writes; supports a pipeline flush from branch resolution.

Parameters:
- XLEN, 32: data/PC width; register values, immediates and PC are XLEN bits.
- NREGS, 32: architectural registers, 16 or 32. Register indices at or above NREGS are decoded as illegal.
- PEND_W, 2: width of each scoreboard pending counter; max outstanding writes per register = 2^PEND_W-1.

Ports:
- req  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- instr_in  in  32  instruction word
- pc_in  in  XLEN  instruction PC
- flush_in  in  1  kill the instruction held in the output register and the one being accepted
- wb_valid  in  1  writeback strobe
- wb_rd  in  5  writeback register
- wb_value  in  XLEN  writeback data
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- pc_out  out  XLEN  registered PC
- rs1_value_out, rs2_value_out  out  XLEN  operands
- imm_value_out  out  XLEN  sign-extended immediate (I/S/B/U/J)
- funct3_out  out  3
- funct7_out  out  7
- alu_op_out  out  7  opcode field
- alu_sub_sra_out  out  1  instr[30] for R-type, or for I-type SRAI
- rd_out  out  5
- rd_write_out  out  1  writes rd (0 if rd==x0)
- branch_out  out  1  B- or J-type
- illegal_out  out  1  unsupported opcode or register index >= NREGS

Behaviour:
- Reset (reset low, asynchronous):
  - out_valid=0; all data outputs 0; illegal_out=0.
  - All scoreboard counters 0; register file cleared to 0.
  - in_ready=0 while reset is low.
- Register file: NREGS x XLEN, x0 reads 0, writes to x0 ignored. Written on req edge when wb_valid and wb_rd!=0.
- Source usage:
  - rs1 used by R, I-op, I-load, S, B.
  - rs2 used by R, S, B.
  - U and J use none.
- Hazard: a used source rs with pending[rs]!=0 stalls, except pending[rs]==1 && wb_valid && wb_rd==rs (see bypass).
- Issue fire = in_valid && in_ready, where in_ready = !hazard && !sat && (!out_valid || out_ready).
  - sat: instruction writes rd and pending[rd] is at maximum.
- Latency: one cycle from fire to out_valid.
- Output register:
  - Loads on fire.
  - Holds all fields while out_valid && !out_ready.
  - Clears out_valid on a consume without a new fire.
- Scoreboard, per register, same edge:
  - +1 when fire and rd_write.
  - -1 when wb_valid for that register.
  - Both events in the same cycle leave it unchanged.
  - Never underflows: a decrement at 0 is ignored.
- Flush (flush_in high):
  - Suppresses fire this cycle, clears out_valid.
  - Decrements pending[rd_out] if the killed output instruction had rd_write.
  - Coincident with a wb to the same register: both decrements apply, saturating at 0.
- Illegal instruction: issued with illegal_out=1, rd_write_out=0, no scoreboard increment.
- Immediate: per opcode format, sign-extended from instr[31] to XLEN.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined: a same-cycle writeback to a used source forwards wb_value into the output register and lifts the hazard.
- Undefined: no forwarding; that case stalls one extra cycle until the register file holds the value. Scoreboard logic is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - opcode constants R_TYPE, I_TYPE_OP, I_TYPE_LD, U_TYPE, B_TYPE, J_TYPE, S_TYPE;
  - imm_fmt_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE);
  - decode_t struct for the output bundle.
- One sub-module, decode_scoreboard: counters, hazard and saturation signals, flush decrement.
- Register file and immediate generation stay inline.

Test Plan:
- Reset mid-stream: assert reset low while out_valid=1 -> out_valid=0 immediately (asynchronous), counters 0, in_ready=0 until release.
- ADD x3,x1,x2 with x1=5, x2=7 -> next cycle out_valid=1, rs1_value_out=5, rs2_value_out=7, rd_out=3, rd_write_out=1; pending[3]=1.
- ADDI x4,x3,1 right after, no wb -> in_ready=0. Then wb x3=12:
  - with DECODE_BYPASS_EN: issue that cycle with rs1_value_out=12;
  - without: issue the following cycle with rs1_value_out=12.
- Backpressure: out_ready=0 for 3 cycles with LUI x5,0x12345 held -> outputs stable, imm_value_out=0x12345000, in_ready=0; release -> one consume.
- Flush with LW x6 in the output register (pending[6]=1) -> out_valid=0 next cycle, pending[6]=0, a following read of x6 does not stall.
- Saturation at PEND_W=2: three outstanding writes to x7 without wb -> fourth writer of x7 stalls. Opcode 7'b1111111 -> illegal_out=1, rd_write_out=0.
